// File: rtl/core_dequant_pkg.sv
// Shared width helpers and default parameter values for the dequantizer datapath.
package core_dequant_pkg;

  localparam int DEF_IDATA_BIT              = 8;
  localparam int DEF_ODATA_WIDTH            = 24;
  localparam int DEF_CDATA_SCALE_WIDTH      = 16;
  localparam int DEF_CDATA_BIAS_WIDTH       = 16;
  localparam int DEF_CDATA_SHIFT_WIDTH      = 5;
  localparam int DEF_DEQUANT_SCALE_RETIMING = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra bit so (idata - zp) is exact for any operand pair.
  function automatic int diff_bit(input int idata_bit, input int bias_width);
    return max_int(idata_bit, bias_width) + 1;
  endfunction

  // Scale is treated as a signed operand with a forced zero sign bit.
  function automatic int prod_bit(input int diff_width, input int scale_width);
    return diff_width + scale_width + 1;
  endfunction

endpackage

// File: rtl/core_dequant_delay.sv
// N-deep register chain for data plus valid, advanced by a shared enable.
module core_dequant_delay #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             any_valid
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign out_data    = in_data;
    assign out_valid   = in_valid;
    assign any_valid   = 1'b0;
  end else begin : g_chain
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        valid_q <= '0;
      end else if (en) begin
        data_q[0]  <= in_data;
        valid_q[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign any_valid = |valid_q;
  end

endmodule

// File: rtl/core_dequant.sv
// Dequantizer: odata = sat(round(((idata - zp) * scale) >>> shift)), fully pipelined
// with a single global advance enable shared by every stage.
module core_dequant
  import core_dequant_pkg::*;
#(
  parameter int IDATA_BIT              = DEF_IDATA_BIT,
  parameter int ODATA_WIDTH            = DEF_ODATA_WIDTH,
  parameter int CDATA_SCALE_WIDTH      = DEF_CDATA_SCALE_WIDTH,
  parameter int CDATA_BIAS_WIDTH       = DEF_CDATA_BIAS_WIDTH,
  parameter int CDATA_SHIFT_WIDTH      = DEF_CDATA_SHIFT_WIDTH,
  parameter int DEQUANT_SCALE_RETIMING = DEF_DEQUANT_SCALE_RETIMING
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CDATA_SCALE_WIDTH-1:0] cfg_dequant_scale,
  input  logic [CDATA_BIAS_WIDTH-1:0]  cfg_dequant_zp,
  input  logic [CDATA_SHIFT_WIDTH-1:0] cfg_dequant_shift,
  input  logic [IDATA_BIT-1:0]         idata,
  input  logic                         idata_valid,
  output logic                         idata_ready,
  output logic [ODATA_WIDTH-1:0]       odata,
  output logic                         odata_valid,
  input  logic                         odata_ready,
  output logic                         odata_sat,
  output logic                         busy
);

  localparam int DIFF_BIT = diff_bit(IDATA_BIT, CDATA_BIAS_WIDTH);
  localparam int PROD_BIT = prod_bit(DIFF_BIT, CDATA_SCALE_WIDTH);

  logic en;
  assign en          = !odata_valid | odata_ready;
  assign idata_ready = en;

  logic signed [DIFF_BIT-1:0] diff_d, diff_q;
  logic                       s1_valid;
  logic signed [PROD_BIT-1:0] diff_ext, scale_ext, prod_d, prod_q;
  logic                       s2_valid;
  logic [PROD_BIT-1:0]        prod_r;
  logic                       r_valid, r_any_valid;
  logic signed [PROD_BIT:0]   prod_ext, prod_sh, rnd_src;
  logic                       rnd;
  logic [PROD_BIT:0]          shifted_d, shifted_q;
  logic                       s3_valid;
  logic [PROD_BIT-ODATA_WIDTH+1:0] upper;
  logic                       in_range;

  assign diff_d = {{(DIFF_BIT-IDATA_BIT){idata[IDATA_BIT-1]}}, idata}
                - {{(DIFF_BIT-CDATA_BIAS_WIDTH){cfg_dequant_zp[CDATA_BIAS_WIDTH-1]}}, cfg_dequant_zp};

  assign diff_ext  = {{(PROD_BIT-DIFF_BIT){diff_q[DIFF_BIT-1]}}, diff_q};
  assign scale_ext = {{(PROD_BIT-CDATA_SCALE_WIDTH){1'b0}}, cfg_dequant_scale};
  assign prod_d    = diff_ext * scale_ext;

  core_dequant_delay #(
    .WIDTH (PROD_BIT),
    .DEPTH (DEQUANT_SCALE_RETIMING)
  ) u_retime (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_data   (prod_q),
    .in_valid  (s2_valid),
    .out_data  (prod_r),
    .out_valid (r_valid),
    .any_valid (r_any_valid)
  );

  // Shifting by (shift-1) picks the rounding bit and yields the sign bit once
  // the index runs past the top of the product.
  assign prod_ext  = {prod_r[PROD_BIT-1], prod_r};
  assign prod_sh   = prod_ext >>> cfg_dequant_shift;
  assign rnd_src   = prod_ext >>> CDATA_SHIFT_WIDTH'(cfg_dequant_shift - 1'b1);
  assign rnd       = (cfg_dequant_shift != '0) & rnd_src[0];
  assign shifted_d = prod_sh + {{PROD_BIT{1'b0}}, rnd};

  assign upper    = shifted_q[PROD_BIT:ODATA_WIDTH-1];
  assign in_range = (&upper) | ~(|upper);

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q      <= '0;
      s1_valid    <= 1'b0;
      prod_q      <= '0;
      s2_valid    <= 1'b0;
      shifted_q   <= '0;
      s3_valid    <= 1'b0;
      odata       <= '0;
      odata_valid <= 1'b0;
      odata_sat   <= 1'b0;
    end else if (en) begin
      diff_q      <= diff_d;
      s1_valid    <= idata_valid;
      prod_q      <= prod_d;
      s2_valid    <= s1_valid;
      shifted_q   <= shifted_d;
      s3_valid    <= r_valid;
      odata_valid <= s3_valid;
      if (in_range) begin
        odata     <= shifted_q[ODATA_WIDTH-1:0];
        odata_sat <= 1'b0;
      end else begin
        odata     <= shifted_q[PROD_BIT] ? {1'b1, {(ODATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ODATA_WIDTH-1){1'b1}}};
        odata_sat <= 1'b1;
      end
    end
  end

  assign busy = s1_valid | s2_valid | r_any_valid | s3_valid | odata_valid;

endmodule

// File: tb/tb_core_dequant.sv
// Directed bench for core_dequant at default parameters (latency 5).
module tb_core_dequant;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_dequant_scale;
  logic [15:0] cfg_dequant_zp;
  logic [4:0]  cfg_dequant_shift;
  logic [7:0]  idata;
  logic        idata_valid;
  logic        idata_ready;
  logic [23:0] odata;
  logic        odata_valid;
  logic        odata_ready;
  logic        odata_sat;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  core_dequant dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_dequant_scale (cfg_dequant_scale),
    .cfg_dequant_zp    (cfg_dequant_zp),
    .cfg_dequant_shift (cfg_dequant_shift),
    .idata             (idata),
    .idata_valid       (idata_valid),
    .idata_ready       (idata_ready),
    .odata             (odata),
    .odata_valid       (odata_valid),
    .odata_ready       (odata_ready),
    .odata_sat         (odata_sat),
    .busy              (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one sample with odata_ready high and measures cycles until odata_valid.
  task automatic applyStimulus(input logic [15:0] zp, input logic [15:0] sc, input logic [4:0] sh,
                               input logic [7:0] din, output int lat);
    cfg_dequant_zp    = zp;
    cfg_dequant_scale = sc;
    cfg_dequant_shift = sh;
    idata             = din;
    idata_valid       = 1'b1;
    @(posedge clk);
    #1 idata_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!odata_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic runCase(input string tag, input logic [15:0] zp, input logic [15:0] sc,
                         input logic [4:0] sh, input logic [7:0] din,
                         input logic [23:0] exp_data, input logic exp_sat);
    int lat;
    applyStimulus(zp, sc, sh, din, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd5);
    checkOutput({tag, "_odata"}, {8'h0, odata}, {8'h0, exp_data});
    checkOutput({tag, "_sat"}, {31'h0, odata_sat}, {31'h0, exp_sat});
    @(posedge clk);
    #1;
  endtask

  int got_q[$];

  initial begin
    rst               = 1'b1;
    idata             = '0;
    idata_valid       = 1'b0;
    odata_ready       = 1'b1;
    cfg_dequant_zp    = '0;
    cfg_dequant_scale = 16'd1;
    cfg_dequant_shift = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_odata", {8'h0, odata}, 32'h0);
    checkOutput("reset_valid", {31'h0, odata_valid}, 32'h0);
    checkOutput("reset_sat", {31'h0, odata_sat}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", {31'h0, idata_ready}, 32'h1);
    @(posedge clk);
    #1;

    runCase("neg128",   16'h0000, 16'd1,     5'd0, 8'h80,  24'hFFFF80, 1'b0);
    runCase("scale256", 16'd3,    16'd256,   5'd4, 8'd10,  24'd112,    1'b0);
    runCase("rnd_pos",  16'h0000, 16'd3,     5'd1, 8'd1,   24'd2,      1'b0);
    runCase("rnd_neg",  16'h0000, 16'd3,     5'd1, 8'hFF,  24'hFFFFFF, 1'b0);
    runCase("sat_pos",  16'h8000, 16'hFFFF,  5'd0, 8'd127, 24'h7FFFFF, 1'b1);
    runCase("sat_neg",  16'h7FFF, 16'hFFFF,  5'd0, 8'h80,  24'h800000, 1'b1);

    // Backpressure: 8 back-to-back samples, output stalled for 3 cycles at the first result.
    cfg_dequant_zp    = '0;
    cfg_dequant_scale = 16'd1;
    cfg_dequant_shift = '0;
    fork
      begin : driver
        int sent = 0;
        logic xfer;
        idata       = 8'd1;
        idata_valid = 1'b1;
        for (int guard = 0; guard < 60 && sent < 8; guard++) begin
          @(negedge clk);
          xfer = idata_valid && idata_ready;
          @(posedge clk);
          #1;
          if (xfer) begin
            sent++;
            if (sent < 8) idata = 8'(sent + 1);
            else idata_valid = 1'b0;
          end
        end
        idata_valid = 1'b0;
        checkOutput("bp_all_sent", 32'(sent), 32'd8);
      end
      begin : stall_ctrl
        bit seen = 1'b0;
        for (int guard = 0; guard < 30 && !seen; guard++) begin
          @(posedge clk);
          #1;
          if (odata_valid) seen = 1'b1;
        end
        checkOutput("bp_first_out_seen", {31'h0, seen}, 32'h1);
        odata_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checkOutput($sformatf("bp_stall%0d_ready", c), {31'h0, idata_ready}, 32'h0);
          checkOutput($sformatf("bp_stall%0d_odata", c), {8'h0, odata}, 32'd1);
          @(posedge clk);
          #1;
        end
        odata_ready = 1'b1;
      end
      begin : monitor
        for (int guard = 0; guard < 80 && got_q.size() < 8; guard++) begin
          @(negedge clk);
          if (odata_valid && odata_ready) got_q.push_back(int'(odata));
        end
      end
    join
    checkOutput("bp_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      checkOutput($sformatf("bp_order%0d", i), 32'(got_q[i]), 32'(i + 1));
    repeat (2) @(posedge clk);
    #1;

    // Reset with three samples still in the pipe.
    idata_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idata = 8'(5 + i);
      @(posedge clk);
      #1;
    end
    idata_valid = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    checkOutput("mid_busy_before", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_valid", {31'h0, odata_valid}, 32'h0);
    checkOutput("mid_busy", {31'h0, busy}, 32'h0);
    checkOutput("mid_odata", {8'h0, odata}, 32'h0);
    checkOutput("mid_ready", {31'h0, idata_ready}, 32'h1);
    @(posedge clk);
    #1;
    runCase("post_reset", 16'h0000, 16'd2, 5'd0, 8'd9, 24'd18, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("final_idle", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/core_dequant.md
Name: core_dequant

Overview:
- Inverse of the accumulator quantizer. Converts narrow signed integers (activations/weights as stored) back to wide signed fixed-point for the accumulator/softmax/layernorm datapath.
- Computes odata = sat(round(((idata - zero_point) * scale) >>> shift)).
- Fully pipelined, one sample per cycle, with valid/ready backpressure on both sides.

Parameters:
- IDATA_BIT, 8: input integer width (signed).
- ODATA_WIDTH, 24: output width (signed, saturated).
- CDATA_SCALE_WIDTH, 16: scale width (unsigned magnitude).
- CDATA_BIAS_WIDTH, 16: zero-point width (signed).
- CDATA_SHIFT_WIDTH, 5: right-shift amount width.
- DEQUANT_SCALE_RETIMING, 1: extra register stages after the multiplier. Legal range 0..4.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- cfg_dequant_scale, in, CDATA_SCALE_WIDTH: unsigned scale.
- cfg_dequant_zp, in, CDATA_BIAS_WIDTH: signed zero point.
- cfg_dequant_shift, in, CDATA_SHIFT_WIDTH: right shift.
- idata, in, IDATA_BIT: signed input sample.
- idata_valid, in, 1: input valid.
- idata_ready, out, 1: block accepts idata this cycle.
- odata, out, ODATA_WIDTH: signed dequantized result.
- odata_valid, out, 1: output valid.
- odata_ready, in, 1: downstream accepts odata.
- odata_sat, out, 1: odata was clamped; qualified by odata_valid.
- busy, out, 1: any pipeline stage holds valid data.

Behaviour:
- Reset (rst high at a clk edge):
  - Every stage's valid bit and data register clears.
  - odata=0, odata_valid=0, odata_sat=0, busy=0.
  - idata_ready=1 from the first cycle after reset.
  - Reset mid-stream discards in-flight samples silently.
- Global advance enable: en = !odata_valid | odata_ready.
  - idata_ready = en (combinational).
  - Every stage register, data and valid together, loads only when en=1. When en=0 all stages hold.
  - Bubbles are not compressed. This is accepted; no skid buffer.
- Transfers: input transfer is idata_valid & idata_ready. Output transfer is odata_valid & odata_ready.
- While odata_valid=1 and odata_ready=0, odata and odata_sat stay stable.
- Stages, each registered with a valid bit:
  - S1: diff = sext(idata) - sext(cfg_dequant_zp). Width DIFF_BIT = max(IDATA_BIT, CDATA_BIAS_WIDTH)+1. Exact, never overflows.
  - S2: prod = diff * signed({1'b0, scale}). Width PROD_BIT = DIFF_BIT + CDATA_SCALE_WIDTH + 1.
  - R0..R(DEQUANT_SCALE_RETIMING-1): plain delay stages carrying prod and valid. With 0 stages, S2 feeds S3 directly.
  - S3: shifted = (prod >>> shift) + rnd. Width PROD_BIT+1.
    - rnd = prod[shift-1] when shift>0, else 0.
    - If shift-1 >= PROD_BIT, rnd = sign bit of prod.
    - Result is round-half-up toward +inf on the discarded fraction.
  - S4: saturate shifted into ODATA_WIDTH. The upper bits [PROD_BIT:ODATA_WIDTH-1] must all equal the sign bit; otherwise clamp.
    - Positive overflow gives 2^(ODATA_WIDTH-1)-1 with odata_sat=1.
    - Negative overflow gives -2^(ODATA_WIDTH-1) with odata_sat=1.
    - S4 registers drive odata, odata_valid and odata_sat.
- Latency, no stall: 4 + DEQUANT_SCALE_RETIMING cycles from input transfer to odata_valid. 5 cycles at defaults.
- Throughput: 1 sample/cycle while odata_ready=1.
- Config inputs are sampled live at S1 (zp), S2 (scale) and S3 (shift).
  - They must be held stable while busy=1. Changing them while busy=1 gives undefined values but no lockup.
- busy = OR of all stage valid bits.
- Simultaneous output transfer and new input in the same cycle is a normal advance. No sample is lost or duplicated; order is preserved.

Decomposition:
- Shared package: width helpers DIFF_BIT and PROD_BIT, with max() as a constant function.
- Default macros in the existing global define file, alongside the quantizer defines: DEQUANT_SCALE_RETIMING, CDATA_* widths, IDATA_BIT, ODATA_WIDTH.
- One sub-module, core_dequant_delay: a parameterized N-deep register chain of data+valid with enable.
  - Used for the R stages.
  - N=0 is a wire-through.

Test Plan (defaults, so latency is 5):
- Reset release, then zp=0, scale=1, shift=0, idata=0x80 (-128) -> 5 cycles later odata=0xFFFF80, odata_sat=0.
- zp=3, scale=256, shift=4, idata=10 -> odata=112.
- Rounding:
  - zp=0, scale=3, shift=1, idata=1 -> odata=2.
  - Same config, idata=-1 -> odata=-1 (0xFFFFFF).
- Saturation, shift=0, scale=65535:
  - zp=-32768, idata=127 -> odata=0x7FFFFF, odata_sat=1.
  - zp=32767, idata=-128 -> odata=0x800000, odata_sat=1.
- Backpressure: 8 back-to-back inputs 1..8 (zp=0, scale=1, shift=0). Drop odata_ready for 3 cycles at the first output.
  - idata_ready is low during those same 3 cycles.
  - odata holds 1.
  - Outputs arrive as exactly 1..8 in order, none duplicated.
- Reset mid-stream with 3 samples in flight:
  - Next cycle: odata_valid=0, busy=0, odata=0, idata_ready=1.
  - A new sample afterwards emerges exactly 5 cycles after its input transfer.
